mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 178 +++++++++++++++++
 tb/tb_mem_access.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM stage: issues data-memory requests for loads/stores and
// registers the MEM/WB bundle.
//
// Ports:
//   clk_i, rst_i         clock, async active-low reset
//   WB_i, ALUOut_i,      EX/MEM bundle: wb ctrl, alu result/address,
//   wdata_i, rd_i        store data, destination register
//   MemRead_i/Write_i    load / store request
//   mem_req_o, mem_we_o, external memory request, write enable,
//   mem_addr_o,          address and store data (held while waiting)
//   mem_wdata_o
//   mem_ack_i,           one-cycle completion pulse with read data
//   mem_rdata_i
//   stall_o              freeze upstream stages this cycle
//   err_o                one-cycle pulse: misaligned access or timeout
//   WB_o, MemData_o,     registered MEM/WB bundle
//   ALUOut_o, rd_o
module mem_access #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  WB_i,
  input  logic [31:0] ALUOut_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        err_o,
  output logic [1:0]  WB_o,
  output logic [31:0] MemData_o,
  output logic [31:0] ALUOut_o,
  output logic [4:0]  rd_o
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  // Last wait-counter value before the access is abandoned.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  // Access latched on entry to WAIT.
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  lwb_q, lwb_d;
  logic [4:0]  lrd_q, lrd_d;

  logic        err_q, err_d;
  logic [1:0]  wb_d;
  logic [31:0] alu_d;
  logic [4:0]  rd_d;
  logic [31:0] md_d;
  logic        stall;

  logic        access;
  logic        misal;

  assign access = MemRead_i | MemWrite_i;
  assign misal  = |ALUOut_i[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    lwb_d   = lwb_q;
    lrd_d   = lrd_q;
    err_d   = 1'b0;
    wb_d    = WB_o;
    alu_d   = ALUOut_o;
    rd_d    = rd_o;
    md_d    = MemData_o;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!access) begin
          wb_d  = WB_i;
          alu_d = ALUOut_i;
          rd_d  = rd_i;
        end else if (misal) begin
          // Drop the access: kill writeback, flag error next cycle.
          wb_d  = 2'b00;
          alu_d = ALUOut_i;
          rd_d  = rd_i;
          err_d = 1'b1;
        end else begin
          stall   = 1'b1;
          state_d = S_WAIT;
          cnt_d   = 8'd0;
          addr_d  = ALUOut_i;
          wdata_d = wdata_i;
          we_d    = MemWrite_i;
          lwb_d   = WB_i;
          lrd_d   = rd_i;
          wb_d    = 2'b00;
        end
      end
      S_WAIT: begin
        wb_d = 2'b00;
        if (mem_ack_i) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
          wb_d    = lwb_q;
          alu_d   = addr_q;
          rd_d    = lrd_q;
          if (!we_q) begin
            md_d = mem_rdata_i;
          end
        end else if (cnt_q == LAST_CNT) begin
          // Give up: release the pipeline, retire a bubble.
          state_d = S_IDLE;
          cnt_d   = 8'd0;
          err_d   = 1'b1;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      lwb_q     <= 2'b00;
      lrd_q     <= 5'd0;
      err_q     <= 1'b0;
      WB_o      <= 2'b00;
      ALUOut_o  <= 32'd0;
      rd_o      <= 5'd0;
      MemData_o <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      lwb_q     <= lwb_d;
      lrd_q     <= lrd_d;
      err_q     <= err_d;
      WB_o      <= wb_d;
      ALUOut_o  <= alu_d;
      rd_o      <= rd_d;
      MemData_o <= md_d;
    end
  end

  // Request follows state, so an async reset drops it at once.
  assign mem_req_o   = (state_q == S_WAIT);
  assign mem_we_o    = mem_req_o & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  // Stall is combinational from inputs; mask it while in reset.
  assign stall_o     = rst_i & stall;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access (TIMEOUT_CYC = 4).
// Directed cycles push expected outputs; a negedge monitor checks.
module tb_mem_access;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [1:0]  WB_i = '0;
  logic [31:0] ALUOut_i = '0;
  logic [31:0] wdata_i = '0;
  logic [4:0]  rd_i = '0;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        stall_o;
  logic        err_o;
  logic [1:0]  WB_o;
  logic [31:0] MemData_o;
  logic [31:0] ALUOut_o;
  logic [4:0]  rd_o;

  mem_access #(.TIMEOUT_CYC(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .WB_i        (WB_i),
    .ALUOut_i    (ALUOut_i),
    .wdata_i     (wdata_i),
    .rd_i        (rd_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_o     (stall_o),
    .err_o       (err_o),
    .WB_o        (WB_o),
    .MemData_o   (MemData_o),
    .ALUOut_o    (ALUOut_o),
    .rd_o        (rd_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       nm;
    logic        stall;
    logic        req;
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] md;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Hand-tracked expected register contents.
  logic [31:0] e_addr = 0, e_wd = 0, e_alu = 0, e_md = 0;
  logic [1:0]  e_wb = 0;
  logic [4:0]  e_rd = 0;
  logic        e_err = 0;

  task automatic chk(input string nm, input string f,
                     input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s.%s got %h expected %h", nm, f, a, e);
    end
  endtask

  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "stall", 32'(stall_o), 32'(e.stall));
      chk(e.nm, "req", 32'(mem_req_o), 32'(e.req));
      chk(e.nm, "we", 32'(mem_we_o), 32'(e.we));
      chk(e.nm, "err", 32'(err_o), 32'(e.err));
      chk(e.nm, "addr", mem_addr_o, e.addr);
      chk(e.nm, "wdata", mem_wdata_o, e.wdata);
      chk(e.nm, "WB", 32'(WB_o), 32'(e.wb));
      chk(e.nm, "ALUOut", ALUOut_o, e.alu);
      chk(e.nm, "rd", 32'(rd_o), 32'(e.rd));
      chk(e.nm, "MemData", MemData_o, e.md);
    end
  end

  task automatic drive(input logic [1:0] wb, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input logic mr, input logic mw,
                       input logic ack, input logic [31:0] rdata);
    @(posedge clk_i);
    #1;
    WB_i = wb;
    ALUOut_i = alu;
    wdata_i = wd;
    rd_i = rd;
    MemRead_i = mr;
    MemWrite_i = mw;
    mem_ack_i = ack;
    mem_rdata_i = rdata;
  endtask

  task automatic push(input string nm, input logic stall,
                      input logic req, input logic we);
    exp_t e;
    e.nm = nm;
    e.stall = stall;
    e.req = req;
    e.we = we;
    e.err = e_err;
    e.addr = e_addr;
    e.wdata = e_wd;
    e.wb = e_wb;
    e.alu = e_alu;
    e.rd = e_rd;
    e.md = e_md;
    q.push_back(e);
  endtask

  task automatic idle();
    drive(2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset held low
    idle(); push("reset0", 0, 0, 0);
    idle(); push("reset1", 0, 0, 0);
    @(posedge clk_i); #1 rst_i = 1'b1;
    WB_i = 2'b01; ALUOut_i = 32'h10; rd_i = 5'd5;
    push("alu_in", 0, 0, 0);
    idle();
    e_wb = 2'b01; e_alu = 32'h10; e_rd = 5'd5;
    push("alu_out", 0, 0, 0);

    // Load 0x40, ack after 3 WAIT cycles
    drive(2'b11, 32'h40, 32'h0, 5'd7, 1, 0, 0, 32'h0);
    e_wb = 0; e_alu = 0; e_rd = 0;
    push("ld_idle", 1, 0, 0);
    e_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 32'h40, 32'h0, 5'd7, 1, 0, 0, 32'h0);
      push("ld_wait", 1, 1, 0);
    end
    drive(2'b11, 32'h40, 32'h0, 5'd7, 1, 0, 1, 32'hDEADBEEF);
    push("ld_ack", 0, 1, 0);
    idle();
    e_wb = 2'b11; e_alu = 32'h40; e_rd = 5'd7; e_md = 32'hDEADBEEF;
    push("ld_done", 0, 0, 0);

    // Store 0x44, ack in first WAIT cycle
    drive(2'b00, 32'h44, 32'h12345678, 5'd0, 0, 1, 0, 32'h0);
    e_wb = 0; e_alu = 0; e_rd = 0;
    push("st_idle", 1, 0, 0);
    drive(2'b00, 32'h44, 32'h12345678, 5'd0, 0, 1, 1, 32'hFFFFFFFF);
    e_addr = 32'h44; e_wd = 32'h12345678;
    push("st_ack", 0, 1, 1);
    idle();
    e_alu = 32'h44;
    push("st_done", 0, 0, 0);

    // Misaligned load 0x42
    drive(2'b11, 32'h42, 32'h0, 5'd9, 1, 0, 0, 32'h0);
    e_alu = 0;
    push("mis_in", 0, 0, 0);
    idle();
    e_alu = 32'h42; e_rd = 5'd9; e_err = 1;
    push("mis_err", 0, 0, 0);
    idle();
    e_alu = 0; e_rd = 0; e_err = 0;
    push("mis_clr", 0, 0, 0);

    // Timeout load 0x80, no ack
    drive(2'b11, 32'h80, 32'h0, 5'd3, 1, 0, 0, 32'h0);
    push("to_idle", 1, 0, 0);
    e_addr = 32'h80; e_wd = 0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 32'h80, 32'h0, 5'd3, 1, 0, 0, 32'h0);
      push("to_wait", 1, 1, 0);
    end
    drive(2'b11, 32'h80, 32'h0, 5'd3, 1, 0, 0, 32'h0);
    push("to_last", 0, 1, 0);
    idle();
    e_err = 1;
    push("to_err", 0, 0, 0);

    // Ack in IDLE ignored
    drive(2'b00, 32'h0, 32'h0, 5'd0, 0, 0, 1, 32'h55);
    e_err = 0;
    push("idle_ack", 0, 0, 0);
    idle();
    push("idle_ack2", 0, 0, 0);

    // Reset in the second WAIT cycle
    drive(2'b11, 32'hC0, 32'h0, 5'd4, 1, 0, 0, 32'h0);
    push("rw_idle", 1, 0, 0);
    drive(2'b11, 32'hC0, 32'h0, 5'd4, 1, 0, 0, 32'h0);
    e_addr = 32'hC0;
    push("rw_wait", 1, 1, 0);
    drive(2'b11, 32'hC0, 32'h0, 5'd4, 1, 0, 0, 32'h0);
    rst_i = 1'b0;
    e_addr = 0; e_wd = 0; e_wb = 0; e_alu = 0; e_rd = 0; e_md = 0;
    push("rw_async", 0, 0, 0);
    drive(2'b11, 32'hC0, 32'h0, 5'd4, 1, 0, 1, 32'h99);
    push("rw_hold", 0, 0, 0);
    drive(2'b00, 32'h0, 32'h0, 5'd0, 0, 0, 1, 32'h99);
    rst_i = 1'b1;
    push("rw_late", 0, 0, 0);
    idle();
    push("rw_after", 0, 0, 0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk_i);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
